ai_paddle_ctrl: RTL



---
 rtl/pong_pkg.sv | 17 +
 rtl/ai_jitter_lfsr.sv | 25 ++
 rtl/ai_paddle_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared Pong screen constants and AI controller state encoding.
// Used by the paddle, ball and AI opponent modules.
package pong_pkg;

    localparam int PADDLE_H = 80;
    localparam int BALL_H   = 8;
    localparam int Y_MAX    = 280;
    localparam int HOME_Y   = 200;

    typedef enum logic [1:0] {
        AI_IDLE   = 2'd0,
        AI_REACT  = 2'd1,
        AI_TRACK  = 2'd2,
        AI_RETURN = 2'd3
    } ai_state_t;

endpackage

// File: rtl/ai_jitter_lfsr.sv
// Aim jitter source: 4-bit LFSR plus an offset latched on REACT entry.
// Only instantiated when AI_JITTER_EN is defined.
module ai_jitter_lfsr (
    input  logic              game_clk,
    input  logic              rst_n,
    input  logic              latch,
    output logic signed [3:0] offset
);

    logic [3:0] lfsr;

    // x^4+x^3+1 shift register; offset = lfsr-8 captured on latch
    always_ff @(posedge game_clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr   <= 4'b1001;
            offset <= '0;
        end else begin
            lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
            if (latch) begin
                offset <= signed'(lfsr - 4'd8);
            end
        end
    end

endmodule

// File: rtl/ai_paddle_ctrl.sv
// Computer Pong opponent: drives one paddle's up/down command pair.
// Define AI_JITTER_EN to add a random aim offset on each REACT entry.
module ai_paddle_ctrl
    import pong_pkg::*;
#(
    parameter int SIDE         = 1,
    parameter int PADDLE_H     = pong_pkg::PADDLE_H,
    parameter int BALL_H       = pong_pkg::BALL_H,
    parameter int Y_MAX        = pong_pkg::Y_MAX,
    parameter int HOME_Y       = pong_pkg::HOME_Y,
    parameter int DEADBAND     = 2,
    parameter int REACT_CYCLES = 10,
    parameter int SPEED_DIV    = 2
) (
    input  logic       game_clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [9:0] ball_y,
    input  logic       ball_dir,
    input  logic [9:0] paddle_y,
    output logic       up,
    output logic       down,
    output logic [1:0] ai_state
);

    localparam int RW = $clog2(REACT_CYCLES + 1);
    localparam int SW = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;

    localparam logic signed [11:0] AIM_OFS =
        12'(BALL_H / 2 - PADDLE_H / 2);
    localparam logic signed [11:0] YMAX_S = 12'(Y_MAX);
    localparam logic signed [11:0] HOME_S = 12'(HOME_Y);
    localparam logic signed [11:0] DB_S   = 12'(DEADBAND);

    ai_state_t state, nxt;
    logic [RW-1:0] react_cnt, react_nxt;
    logic [SW-1:0] step_cnt;

    logic approaching;
    logic pulse;
    logic move;
    logic in_band;
    logic up_d, down_d;

    logic signed [11:0] offset;
    logic signed [11:0] py_s;
    logic signed [11:0] raw;
    logic signed [11:0] target;
    logic signed [11:0] goal;
    logic signed [11:0] err;
    logic signed [11:0] err_home;

`ifdef AI_JITTER_EN
    logic signed [3:0] jit_ofs;
    logic              enter_react;

    assign enter_react = (nxt == AI_REACT) &&
                         ((state == AI_IDLE) ||
                          (state == AI_RETURN));

    ai_jitter_lfsr u_jitter (
        .game_clk (game_clk),
        .rst_n    (rst_n),
        .latch    (enter_react),
        .offset   (jit_ofs)
    );

    assign offset = {{8{jit_ofs[3]}}, jit_ofs};
`else
    assign offset = '0;
`endif

    assign approaching = (ball_dir == 1'(SIDE));
    assign py_s        = signed'({2'b00, paddle_y});
    assign raw         = signed'({2'b00, ball_y}) + AIM_OFS + offset;

    assign target = (raw < 12'sd0)  ? 12'sd0 :
                    (raw > YMAX_S)  ? YMAX_S : raw;

    assign goal     = (state == AI_RETURN) ? HOME_S : target;
    assign err      = goal - py_s;
    assign err_home = HOME_S - py_s;
    assign in_band  = (err_home >= -DB_S) && (err_home <= DB_S);

    assign pulse    = (step_cnt == SW'(SPEED_DIV - 1));
    assign ai_state = state;

    // Next state, react counter and motion pulse decode
    always_comb begin
        nxt       = state;
        react_nxt = react_cnt;
        move      = 1'b0;
        up_d      = 1'b0;
        down_d    = 1'b0;
        if (!enable) begin
            nxt = AI_IDLE;
        end else begin
            unique case (state)
                AI_IDLE: begin
                    if (approaching) begin
                        nxt       = AI_REACT;
                        react_nxt = '0;
                    end
                end
                AI_REACT: begin
                    if (!approaching) begin
                        nxt = AI_RETURN;
                    end else if (react_cnt == RW'(REACT_CYCLES - 1)) begin
                        nxt = AI_TRACK;
                    end else begin
                        react_nxt = react_cnt + 1'b1;
                    end
                end
                AI_TRACK: begin
                    if (!approaching) begin
                        nxt = AI_RETURN;
                    end else begin
                        move = 1'b1;
                    end
                end
                AI_RETURN: begin
                    if (approaching) begin
                        nxt       = AI_REACT;
                        react_nxt = '0;
                    end else if (in_band) begin
                        nxt = AI_IDLE;
                    end else begin
                        move = 1'b1;
                    end
                end
            endcase
        end
        if (move && pulse) begin
            up_d   = (err < -DB_S) && (paddle_y != '0);
            down_d = (err > DB_S) && (py_s < YMAX_S);
        end
    end

    // State, counters and registered up/down commands
    always_ff @(posedge game_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= AI_IDLE;
            react_cnt <= '0;
            step_cnt  <= '0;
            up        <= 1'b0;
            down      <= 1'b0;
        end else begin
            state     <= nxt;
            react_cnt <= react_nxt;
            step_cnt  <= pulse ? '0 : step_cnt + 1'b1;
            up        <= up_d;
            down      <= down_d;
        end
    end

endmodule
